// File: rtl/gpio_in_debounce.sv
// GPIO input conditioner: 2-flop synchroniser, per-bit tick-based debounce,
// sticky edge status and a small Avalon-MM register file (period/bypass/status).
module gpio_in_debounce #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned PRESC          = 50000,
    parameter int unsigned DEFAULT_PERIOD = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              avs_write,
    input  logic [4:0]        avs_address,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic [WIDTH-1:0]  raw_i,
    output logic [WIDTH-1:0]  pio_o,
    output logic              edge_o
);

    localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [4:0] ADDR_STABLE = 5'd0;
    localparam logic [4:0] ADDR_PERIOD = 5'd4;
    localparam logic [4:0] ADDR_BYPASS = 5'd8;
    localparam logic [4:0] ADDR_STATUS = 5'd12;

    logic [WIDTH-1:0]   s1_q, s2_q;
    logic [WIDTH-1:0]   stable_q, stable_d;
    logic [WIDTH-1:0]   bypass_q, bypass_d;
    logic [WIDTH-1:0]   status_q, status_d;
    logic [WIDTH-1:0]   chg;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   cnt_q [WIDTH];
    logic [CNT_W-1:0]   cnt_d [WIDTH];
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic               edge_q, edge_d;
    logic               debounce_off;

    assign tick         = (presc_q == PRESC_W'(PRESC - 1));
    assign debounce_off = (period_q == '0);

    // Free-running tick prescaler
    always_comb begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    // Per-bit debounce: commit after `period` consecutive mismatching ticks
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (bypass_q[i] || debounce_off) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                // period_q is non-zero here; >= also covers a shrunk period
                if (cnt_q[i] >= period_q - CNT_W'(1)) begin
                    stable_d[i] = s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detect and register writes; a set beats a same-cycle clear
    always_comb begin
        chg      = stable_d ^ stable_q;
        edge_d   = |chg;
        period_d = period_q;
        bypass_d = bypass_q;
        status_d = status_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_PERIOD: period_d = avs_writedata[CNT_W-1:0];
                ADDR_BYPASS: bypass_d = avs_writedata[WIDTH-1:0];
                ADDR_STATUS: status_d = status_q & ~avs_writedata[WIDTH-1:0];
                default:     ;
            endcase
        end
        status_d = status_d | chg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            bypass_q <= '0;
            status_q <= '0;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            presc_q  <= '0;
            edge_q   <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            bypass_q <= bypass_d;
            status_q <= status_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            edge_q   <= edge_d;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Combinational read mux
    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            ADDR_STABLE: avs_readdata = 32'(stable_q);
            ADDR_PERIOD: avs_readdata = 32'(period_q);
            ADDR_BYPASS: avs_readdata = 32'(bypass_q);
            ADDR_STATUS: avs_readdata = 32'(status_q);
            default:     avs_readdata = '0;
        endcase
    end

    assign pio_o  = stable_q;
    assign edge_o = edge_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Randomised and directed bench for gpio_in_debounce against a tick-counting
// reference model of the debounce, status and register behaviour.
module tb_gpio_in_debounce;

    localparam int unsigned W     = 8;
    localparam int unsigned PRESC = 4;
    localparam int unsigned DP    = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        avs_write;
    logic [4:0]  avs_address;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [W-1:0] raw_i;
    logic [W-1:0] pio_o;
    logic        edge_o;

    int checks = 0;
    int errors = 0;

    gpio_in_debounce #(
        .WIDTH(W), .CNT_W(8), .PRESC(PRESC), .DEFAULT_PERIOD(DP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .raw_i(raw_i), .pio_o(pio_o), .edge_o(edge_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference model state
    int unsigned n;
    logic [W-1:0] m_s1, m_s2, m_stable, m_bypass, m_status;
    logic [7:0]   m_period;
    logic         m_edge;
    int           m_run [W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_bypass = '0; m_status = '0;
        m_period = 8'(DP);
        m_edge = 1'b0;
        for (int i = 0; i < int'(W); i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:    return 32'(m_stable);
            5'd4:    return 32'(m_period);
            5'd8:    return 32'(m_bypass);
            5'd12:   return 32'(m_status);
            default: return 32'd0;
        endcase
    endfunction

    // Advance model by one rising edge using the inputs currently driven
    task automatic model_edge();
        logic [W-1:0] nxt;
        bit tk;
        tk = (n % PRESC) == PRESC - 1;
        n++;
        nxt = m_stable;
        for (int i = 0; i < int'(W); i++) begin
            if (m_bypass[i] || m_period == 0) begin
                nxt[i] = m_s2[i];
                m_run[i] = 0;
            end else if (m_s2[i] == m_stable[i]) begin
                m_run[i] = 0;
            end else if (tk) begin
                m_run[i]++;
                if (m_run[i] >= int'(m_period)) begin
                    nxt[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_edge = (nxt != m_stable);
        if (avs_write && avs_address == 5'd12) m_status = m_status & ~avs_writedata[W-1:0];
        m_status = m_status | (nxt ^ m_stable);
        if (avs_write && avs_address == 5'd4) m_period = avs_writedata[7:0];
        if (avs_write && avs_address == 5'd8) m_bypass = avs_writedata[W-1:0];
        m_stable = nxt;
        m_s2 = m_s1;
        m_s1 = raw_i;
    endtask

    function automatic bit will_commit0();
        return !m_bypass[0] && m_period != 0 && m_s2[0] != m_stable[0]
               && (n % PRESC) == PRESC - 1 && m_run[0] + 1 >= int'(m_period);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("pio", 32'(pio_o), 32'(m_stable));
        check("edge", 32'(edge_o), 32'(m_edge));
        check("rdata", avs_readdata, m_read(avs_address));
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        cyc();
        avs_write = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int first, edges, k;
        bit found;
        avs_write = 1'b0; avs_address = '0; avs_writedata = '0; raw_i = '0;
        do_reset();
        #1;
        check("rst_pio", 32'(pio_o), 32'h0);
        check("rst_edge", 32'(edge_o), 32'h0);
        avs_address = 5'd4; #1;
        check("rst_period", avs_readdata, 32'd3);

        // 1: clean step commits after 3 ticks
        avs_address = 5'd0;
        raw_i = 8'h01;
        first = 0; edges = 0;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            if (edge_o) edges++;
            if (pio_o[0] && first == 0) first = c;
        end
        check("step_latency", 32'(first), 32'd12);
        check("step_edges", 32'(edges), 32'd1);
        avs_address = 5'd12; #1;
        check("step_status", avs_readdata, 32'h01);

        // 2: one-tick glitches never commit
        for (int g = 0; g < 5; g++) begin
            raw_i = 8'h00; repeat (4) cyc();
            raw_i = 8'h01; repeat (4) cyc();
        end
        repeat (4) cyc();
        check("glitch_pio", 32'(pio_o), 32'h01);
        check("glitch_status", avs_readdata, 32'h01);

        // 3: bypassed bit follows in exactly 3 edges at two tick phases
        do_write(5'd8, 32'h80);
        for (int p = 0; p < 2; p++) begin
            repeat (p + 1) cyc();
            raw_i = 8'h81; first = 0;
            for (int c = 1; c <= 6; c++) begin
                cyc();
                if (pio_o[7] && first == 0) first = c;
            end
            check("byp_latency", 32'(first), 32'd3);
            raw_i = 8'h01;
            repeat (4) cyc();
        end
        do_write(5'd8, 32'h00);

        // 4: period 0 acts as bypass, then period 2
        do_write(5'd4, 32'h0);
        raw_i = 8'h0F;
        cyc(); cyc();
        check("p0_early", 32'(pio_o), 32'h01);
        cyc();
        check("p0_lat", 32'(pio_o), 32'h0F);
        raw_i = 8'h00;
        do_write(5'd4, 32'h2);
        found = 0;
        for (int c = 0; c < 16 && !found; c++) begin
            cyc();
            if (pio_o == 8'h00) found = 1;
        end
        check("p2_commit", 32'(found), 32'd1);

        // 5: set wins over same-cycle clear
        do_write(5'd12, 32'hFF);
        raw_i = 8'h01;
        for (int c = 0; c < 20 && !m_stable[0]; c++) cyc();
        avs_address = 5'd12; #1;
        check("sw_pre", avs_readdata, 32'h01);
        raw_i = 8'h00;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (will_commit0()) found = 1; else cyc();
        end
        check("sw_found", 32'(found), 32'd1);
        do_write(5'd12, 32'h01);
        check("set_wins", avs_readdata, 32'h01);
        do_write(5'd12, 32'h01);
        check("clear", avs_readdata, 32'h00);

        // 6: async reset mid-count
        do_write(5'd4, 32'h3);
        raw_i = 8'h04;
        for (int c = 0; c < 40 && m_stable != 8'h04; c++) cyc();
        check("pre_rst_pio", 32'(pio_o), 32'h04);
        raw_i = 8'h00;
        for (int c = 0; c < 40 && m_run[2] != 2; c++) cyc();
        check("pre_rst_cnt", 32'(m_run[2]), 32'd2);
        reset_n = 1'b0; #1;
        check("async_pio", 32'(pio_o), 32'h0);
        avs_address = 5'd4; #1;
        check("rst_period2", avs_readdata, 32'd3);
        avs_address = 5'd12; #1;
        check("rst_status2", avs_readdata, 32'd0);
        do_reset();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) raw_i = raw_i ^ 8'($urandom);
            avs_address = 5'($urandom_range(0, 7) * 4);
            avs_write = ($urandom_range(0, 9) == 0);
            k = int'(avs_address);
            if (k == 4)      avs_writedata = 32'($urandom_range(0, 4));
            else if (k == 8) avs_writedata = 32'($urandom & $urandom & 32'hFF);
            else             avs_writedata = $urandom;
            cyc();
            avs_write = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
